// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared FSM states and round-robin search for comp_arbiter
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int RR_MAX   = 32;
   localparam int RR_IDX_W = 5;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_result_t;

   // First set bit at or above ptr, wrapping at nreq; walking offsets downward
   // lets the smallest offset be the last (and winning) assignment.
   function automatic rr_result_t rr_next(input logic [RR_MAX-1:0] req,
                                          input int ptr,
                                          input int nreq);
      rr_result_t res;
      int slot;
      res = '0;
      for (int k = RR_MAX - 1; k >= 0; k--) begin
         if (k < nreq) begin
            slot = ptr + k;
            if (slot >= nreq) slot = slot - nreq;
            if (req[slot]) begin
               res.found = 1'b1;
               res.idx   = RR_IDX_W'(slot);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/comp.sv
// rtl/comp.sv - unsigned magnitude comparator
module comp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/comp_arbiter.sv
// rtl/comp_arbiter.sv - round-robin sequencer sharing one comparator among NREQ requesters
module comp_arbiter
   import comp_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       rsp_valid,
   output logic                  rsp_gt,
   output logic                  rsp_eq,
   output logic                  rsp_lt,
   input  logic [NREQ-1:0]       rsp_ack,
   output logic                  busy
);

   localparam int SEL_W = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic              rsp_gt_q, rsp_gt_d;
   logic              rsp_eq_q, rsp_eq_d;
   logic              rsp_lt_q, rsp_lt_d;
   logic              cmp_gt, cmp_eq, cmp_lt;
   rr_result_t        rr;
   logic [SEL_W-1:0]  win;

   comp #(.WIDTH(WIDTH)) u_comp (
      .a  (a_q),
      .b  (b_q),
      .gt (cmp_gt),
      .eq (cmp_eq),
      .lt (cmp_lt)
   );

   always_comb begin
      rr  = rr_next(RR_MAX'(req), int'(ptr_q), NREQ);
      win = SEL_W'(rr.idx);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      a_d         = a_q;
      b_d         = b_q;
      gnt_d       = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_gt_d    = rsp_gt_q;
      rsp_eq_d    = rsp_eq_q;
      rsp_lt_d    = rsp_lt_q;
      unique case (state_q)
         IDLE: begin
            if (rr.found) begin
               sel_d   = win;
               a_d     = a_in[win*WIDTH +: WIDTH];
               b_d     = b_in[win*WIDTH +: WIDTH];
               gnt_d   = ONE << win;
               ptr_d   = (win == SEL_W'(NREQ - 1)) ? '0 : win + SEL_W'(1);
               state_d = CMP;
            end
         end
         CMP: begin
            rsp_gt_d    = cmp_gt;
            rsp_eq_d    = cmp_eq;
            rsp_lt_d    = cmp_lt;
            rsp_valid_d = ONE << sel_q;
            state_d     = RESP;
         end
         RESP: begin
            // Only the served requester can retire the result.
            if (rsp_ack[sel_q]) begin
               rsp_valid_d = '0;
               rsp_gt_d    = 1'b0;
               rsp_eq_d    = 1'b0;
               rsp_lt_d    = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_gt_q    <= 1'b0;
         rsp_eq_q    <= 1'b0;
         rsp_lt_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         a_q         <= a_d;
         b_q         <= b_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_gt_q    <= rsp_gt_d;
         rsp_eq_q    <= rsp_eq_d;
         rsp_lt_q    <= rsp_lt_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_gt    = rsp_gt_q;
   assign rsp_eq    = rsp_eq_q;
   assign rsp_lt    = rsp_lt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_comp_arbiter.sv
// tb/tb_comp_arbiter.sv - self-checking bench for comp_arbiter against a transaction-level model
module tb_comp_arbiter;

   localparam int WIDTH = 4;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic                  rsp_gt, rsp_eq, rsp_lt;
   logic [NREQ-1:0]       rsp_ack;
   logic                  busy;

   int checks   = 0;
   int failures = 0;

   comp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_gt    (rsp_gt),
      .rsp_eq    (rsp_eq),
      .rsp_lt    (rsp_lt),
      .rsp_ack   (rsp_ack),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one in-flight compare, either awaiting its
   // result (grant cycle) or holding a result until its owner acknowledges.
   bit              m_active     = 1'b0;
   bit              m_has_result = 1'b0;
   int              m_sel        = 0;
   int              m_ptr        = 0;
   logic [WIDTH-1:0] m_a         = '0;
   logic [WIDTH-1:0] m_b         = '0;

   always @(posedge clk or negedge rst_n) begin : model
      int  w;
      int  idx;
      bit  found;
      if (!rst_n) begin
         m_active     <= 1'b0;
         m_has_result <= 1'b0;
         m_sel        <= 0;
         m_ptr        <= 0;
         m_a          <= '0;
         m_b          <= '0;
      end else if (!m_active) begin
         found = 1'b0;
         w     = 0;
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (!found && req[idx]) begin
               found = 1'b1;
               w     = idx;
            end
         end
         if (found) begin
            m_active     <= 1'b1;
            m_has_result <= 1'b0;
            m_sel        <= w;
            m_a          <= a_in[w*WIDTH +: WIDTH];
            m_b          <= b_in[w*WIDTH +: WIDTH];
            m_ptr        <= (w + 1) % NREQ;
         end
      end else if (!m_has_result) begin
         m_has_result <= 1'b1;
      end else if (rsp_ack[m_sel]) begin
         m_active     <= 1'b0;
         m_has_result <= 1'b0;
      end
   end

   logic [NREQ-1:0] e_gnt, e_valid;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         e_gnt   = (m_active && !m_has_result) ? (NREQ'(1) << m_sel) : '0;
         e_valid = m_has_result ? (NREQ'(1) << m_sel) : '0;
         chk("gnt",       32'(gnt),       32'(e_gnt));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
         chk("rsp_gt",    32'(rsp_gt),    32'(m_has_result && (m_a > m_b)));
         chk("rsp_eq",    32'(rsp_eq),    32'(m_has_result && (m_a == m_b)));
         chk("rsp_lt",    32'(rsp_lt),    32'(m_has_result && (m_a < m_b)));
         chk("busy",      32'(busy),      32'(m_active));
         chk("gnt_valid_excl", 32'((|gnt) && (|rsp_valid)), 32'(0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      a_in[i*WIDTH +: WIDTH] = a;
      b_in[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt),       32'(0));
      chk({tag, "_valid"}, 32'(rsp_valid), 32'(0));
      chk({tag, "_res"},   32'({rsp_gt, rsp_eq, rsp_lt}), 32'(0));
      chk({tag, "_busy"},  32'(busy),      32'(0));
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int grants[$];
      rst_n   = 1'b0;
      req     = '0;
      a_in    = '0;
      b_in    = '0;
      rsp_ack = '0;
      repeat (3) step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Single request, A < B
      set_slot(2, 4'b1010, 4'b1111);
      req     = 4'b0100;
      rsp_ack = '1;
      step();
      chk("single_gnt",  32'(gnt),  32'h4);
      chk("single_busy", 32'(busy), 32'h1);
      req = '0;
      step();
      chk("single_valid", 32'(rsp_valid), 32'h4);
      chk("single_lt",    32'(rsp_lt),    32'h1);
      chk("single_gteq",  32'({rsp_gt, rsp_eq}), 32'h0);
      step();
      chk("single_idle",  32'(busy),      32'h0);
      chk("single_done",  32'(rsp_valid), 32'h0);

      // Equal, then greater, on requester 0
      set_slot(0, 4'b1010, 4'b1010);
      req = 4'b0001;
      step();
      chk("eq_gnt", 32'(gnt), 32'h1);
      req = '0;
      step();
      chk("eq_res", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'h2);
      step();
      set_slot(0, 4'b1010, 4'b0000);
      req = 4'b0001;
      step();
      req = '0;
      step();
      chk("gt_res", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'h4);
      step();

      // Round robin from a freshly reset pointer
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      req     = '1;
      rsp_ack = '1;
      for (int s = 0; s < 15; s++) begin
         step();
         if (gnt != '0) grants.push_back(onehot_idx(gnt));
      end
      chk("rr_count", 32'(grants.size()), 32'd5);
      for (int k = 0; k < 5 && k < grants.size(); k++)
         chk($sformatf("rr_order%0d", k), 32'(grants[k]), 32'(k % NREQ));
      req = '0;
      repeat (3) step();

      // Backpressure with wrong-index acks and operand churn
      rsp_ack = '0;
      set_slot(1, 4'b0011, 4'b0101);
      req = 4'b0010;
      step();
      chk("bp_gnt", 32'(gnt), 32'h2);
      req = '0;
      step();
      for (int s = 0; s < 5; s++) begin
         chk("bp_valid", 32'(rsp_valid), 32'h2);
         chk("bp_res",   32'({rsp_gt, rsp_eq, rsp_lt}), 32'h1);
         rsp_ack = NREQ'($urandom) & ~NREQ'(4'b0010);
         a_in    = 16'($urandom);
         b_in    = 16'($urandom);
         req     = NREQ'($urandom);
         step();
      end
      chk("bp_hold_valid", 32'(rsp_valid), 32'h2);
      req     = '0;
      rsp_ack = 4'b0010;
      step();
      chk("bp_ack_valid", 32'(rsp_valid), 32'h0);
      chk("bp_ack_busy",  32'(busy),      32'h0);

      // Reset while in CMP
      req     = '1;
      rsp_ack = '1;
      step();
      chk("rst_pre_busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      step();
      chk("rst_hold_valid", 32'(rsp_valid), 32'h0);
      rst_n = 1'b1;
      step();
      chk("rst_first_gnt",   32'(gnt),       32'h1);
      chk("rst_first_valid", 32'(rsp_valid), 32'h0);
      req = '0;
      repeat (3) step();

      // Randomized traffic against the model
      for (int s = 0; s < 3000; s++) begin
         req     = NREQ'($urandom) & NREQ'($urandom);
         a_in    = 16'($urandom);
         b_in    = ($urandom_range(0, 3) == 0) ? a_in : 16'($urandom);
         rsp_ack = NREQ'($urandom) & NREQ'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            #2;
            chk_all_zero("rand_rst");
            rst_n = 1'b1;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
